param_updown_counter: RTL and testbench

- Synchronous, parametrised up/down counter. It is the successor to the 4-bit ripple down counter.
- Single clock domain. Configurable width and modulus, direction per cycle, parallel load, start/stop control, one-shot or free-running mode.
- Provides a registered terminal-count pulse and busy/done status.
- Used as the general event/timer counter in the datapath.

---
 rtl/counter_pkg.sv | 13 +
 rtl/udc_prescaler.sv | 29 ++
 rtl/param_updown_counter.sv | 100 ++++++++++
 tb/tb_param_updown_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM state encoding and direction constants for param_updown_counter.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/udc_prescaler.sv
// udc_prescaler: PRESCALE-modulo tick generator with synchronous clear.
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset (clears the divider)
//   clr     - restart the divider; the next tick comes PRESCALE edges later
//   tick    - high for one cycle every PRESCALE cycles
module udc_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(PRESCALE - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= (clr || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down event/timer counter with load, start/stop,
// one-shot or wrapping mode, registered terminal-count pulse and busy/done status.
// Optional macro UDC_PRESCALE_EN adds parameter PRESCALE: RUN steps only on a prescaler tick.
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   start    - begin or resume counting
//   stop     - halt counting and hold q
//   dir      - 0 count up, 1 count down
//   oneshot  - 1 stop at the terminal value, 0 wrap
//   load     - parallel load of load_val (clamped to MAX_VAL)
//   load_val - load data
//   q / nq   - count value and its registered inverse
//   tc       - one-cycle terminal-count pulse
//   busy     - high in RUN
//   done     - high in DONE
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = MAX_VAL
`ifdef UDC_PRESCALE_EN
    ,
    parameter int PRESCALE  = 4
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

    state_t           state;
    logic [WIDTH-1:0] reload, q_nx, term, step_val, ld_val;
    logic             at_term, tick, adv;

    assign term     = dir == DIR_DOWN ? '0 : MAXV;
    assign at_term  = q == term;
    assign step_val = dir == DIR_UP ? (q == MAXV ? '0 : q + 1'b1)
                                    : (q == '0 ? MAXV : q - 1'b1);
    assign ld_val   = load_val > MAXV ? MAXV : load_val;
    // a RUN-state advance opportunity this edge (load is resolved separately, ahead of it)
    assign adv      = state == RUN && !stop && tick;
    assign q_nx     = load                          ? ld_val   :
                      adv && !(oneshot && at_term)  ? step_val :
                      state == DONE && start        ? reload   : q;
    assign busy     = state == RUN;
    assign done     = state == DONE;

`ifdef UDC_PRESCALE_EN
    // held cleared outside RUN so the first tick lands PRESCALE edges after entering RUN
    udc_prescaler #(.PRESCALE(PRESCALE)) u_psc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (load || stop || state != RUN),
        .tick    (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            q      <= RSTV;
            nq     <= ~RSTV;
            reload <= RSTV;
            tc     <= 1'b0;
            state  <= IDLE;
        end else begin
            q  <= q_nx;
            nq <= ~q_nx;
            // leaving the terminal value is either a wrap or the oneshot finish; both pulse tc
            tc <= !load && adv && at_term;
            if (load) begin
                reload <= ld_val;
                if (state == DONE) state <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (start && !stop) state <= RUN;
                    RUN:     if (stop) state <= IDLE;
                             else if (tick && oneshot && at_term) state <= DONE;
                    DONE:    if (start) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: randomized + directed scoreboard bench against a behavioural model.
module tb_param_updown_counter;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 11;
    localparam int M       = MAX_VAL + 1;
`ifdef UDC_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic             clk = 1'b1, reset_n = 1'b1;
    logic             start = 0, stop = 0, dir = 0, oneshot = 0, load = 0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] q, nq;
    logic             tc, busy, done;

    param_updown_counter #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
`ifdef UDC_PRESCALE_EN
        ,
        .PRESCALE(P)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .dir(dir),
        .oneshot(oneshot), .load(load), .load_val(load_val),
        .q(q), .nq(nq), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        bit tc;
        bit busy;
        bit done;
    } exp_t;

    exp_t sb[$];
    int   errors = 0, checks = 0;

    // behavioural model: mode 0 idle, 1 running, 2 finished; pc counts cycles since RUN (re)start
    int mq = MAX_VAL, mrl = MAX_VAL, mode = 0, pc = 0;
    bit mtc = 0;
    bit cur_dir = 0, cur_os = 0;

    task automatic push();
        exp_t e;
        e.q = mq; e.tc = mtc; e.busy = mode == 1; e.done = mode == 2;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        mq = MAX_VAL; mrl = MAX_VAL; mode = 0; pc = 0; mtc = 0;
    endtask

    task automatic model_step(bit st, bit sp, bit d, bit os, bit ld, int lv);
        bit fire;
        mtc = 0;
        if (ld) begin
            mq = lv > MAX_VAL ? MAX_VAL : lv;
            mrl = mq;
            if (mode == 2) mode = 0;
            pc = 0;
        end else if (mode == 1 && sp) begin
            mode = 0;
        end else if (mode == 0) begin
            if (st && !sp) begin mode = 1; pc = 0; end
        end else if (mode == 2) begin
            if (st) begin mq = mrl; mode = 1; pc = 0; end
        end else begin
            pc++;
            fire = pc == P;
            if (fire) begin
                pc = 0;
                if (os && mq == (d ? 0 : MAX_VAL)) begin
                    mode = 2;
                    mtc = 1;
                end else begin
                    mtc = d ? mq == 0 : mq == MAX_VAL;
                    mq = (mq + (d ? M - 1 : 1)) % M;
                end
            end
        end
    endtask

    task automatic cyc(bit rst, bit st, bit sp, bit d, bit os, bit ld, int lv);
        @(negedge clk);
        start = st; stop = sp; dir = d; oneshot = os; load = ld; load_val = lv[WIDTH-1:0];
        if (rst) begin
            #2;
            model_reset();
            push();
            reset_n = 0;
            #2;
            reset_n = 1;
        end
        model_step(st, sp, d, os, ld, lv);
        push();
    endtask

    task automatic drive(bit st = 0, bit sp = 0, bit ld = 0, int lv = 0);
        cyc(0, st, sp, cur_dir, cur_os, ld, lv);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive();
    endtask

    logic [WIDTH-1:0] eq;
    exp_t             me;

    initial forever begin
        @(posedge clk or negedge reset_n);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: output at t=%0t with no expectation queued", $time);
        end else begin
            me = sb.pop_front();
            eq = me.q[WIDTH-1:0];
            if (q !== eq || nq !== ~eq || tc !== me.tc || busy !== me.busy || done !== me.done) begin
                errors++;
                $display("FAIL counter t=%0t: got q=%0d nq=%0d tc=%b busy=%b done=%b, expected q=%0d nq=%0d tc=%b busy=%b done=%b",
                         $time, q, nq, tc, busy, done, eq, ~eq, me.tc, me.busy, me.done);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0);
        // free-running down count through two wraps
        cur_dir = 1; cur_os = 0;
        drive(1);
        idle(2 * M * P + 4);
        // oneshot down from 5 to DONE, then restart from the reload value
        cur_os = 1;
        drive(0, 0, 1, 5);
        drive(1);
        idle(8 * P + 2);
        drive(0, 1);
        drive(1);
        idle(3 * P);
        // up count across the wrap, then a clamped load
        cur_dir = 0; cur_os = 0;
        drive(0, 0, 1, 7);
        drive(1);
        idle(5 * P);
        drive(0, 0, 1, 14);
        idle(2);
        // start and stop together in RUN, resume, load during RUN
        cur_dir = 1;
        drive(0, 0, 1, 6);
        drive(1);
        idle(3 * P);
        drive(1, 1);
        idle(2);
        drive(1);
        idle(2 * P);
        drive(0, 0, 1, 10);
        idle(3 * P);
        // asynchronous reset mid-run
        cyc(1, 0, 0, cur_dir, cur_os, 0, 0);
        idle(2);
        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cur_dir = ~cur_dir;
            if ($urandom_range(0, 31) == 0) cur_os = ~cur_os;
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0, cur_dir, cur_os,
                $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)));
        end
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
